// File: rtl/difftest_pkg.sv
// Shared constants for the difftest register-delta probe: index width helper,
// output record field layout and coalesce counter width.
package difftest_pkg;

    localparam int COAL_W   = 16;
    localparam int COREID_W = 8;

    // Record layout, LSB first: last, snap, coreid, data, idx
    localparam int REC_LAST_LSB = 0;
    localparam int REC_SNAP_LSB = 1;
    localparam int REC_CORE_LSB = 2;
    localparam int REC_DATA_LSB = REC_CORE_LSB + COREID_W;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/difftest_sync_fifo.sv
// Single-clock record FIFO with flop storage; the head entry is presented
// directly from storage so a push becomes visible the following cycle.
module difftest_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    // Zero when empty so the outputs never show stale or unwritten storage
    assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/difftest_arch_reg_delta.sv
// Change-tracking probe: keeps a shadow register file, marks registers that
// changed on each commit sample and streams them out one record per cycle.
module difftest_arch_reg_delta
    import difftest_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 8,
    parameter int SNAP_PERIOD = 1024,
    parameter int SKIP_R0     = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_REGS*DATA_W-1:0]   io_value,
    input  logic [COREID_W-1:0]          io_coreid,
    input  logic                         snap_req,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [idx_w(NUM_REGS)-1:0]   out_idx,
    output logic [DATA_W-1:0]            out_data,
    output logic [COREID_W-1:0]          out_coreid,
    output logic                         out_snap,
    output logic                         out_last,
    output logic [COAL_W-1:0]            coalesce_cnt,
    output logic                         busy
);

    localparam int IDX_W  = idx_w(NUM_REGS);
    localparam int REC_W  = REC_DATA_LSB + DATA_W + IDX_W;
    localparam int PCNT_W = idx_w((SNAP_PERIOD > 1) ? SNAP_PERIOD : 2);
    localparam logic [PCNT_W-1:0] PERIOD_LAST = PCNT_W'((SNAP_PERIOD > 0) ? SNAP_PERIOD - 1 : 0);
    localparam logic [NUM_REGS-1:0] TRACK_MASK =
        (SKIP_R0 != 0) ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};

    logic [DATA_W-1:0]   shadow_reg [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_reg;
    logic [NUM_REGS-1:0] dirty_next;
    logic                snap_reg;
    logic                snap_next;
    logic [PCNT_W-1:0]   period_cnt_reg;
    logic [PCNT_W-1:0]   period_cnt_next;
    logic [COREID_W-1:0] coreid_reg;
    logic [COAL_W-1:0]   coalesce_reg;
    logic [COAL_W-1:0]   coalesce_next;

    logic [NUM_REGS-1:0] changed;
    logic [NUM_REGS-1:0] push_onehot;
    logic [IDX_W-1:0]    push_idx;
    logic                push_ok;
    logic                pop;
    logic                period_hit;
    logic                snap_trig;
    logic                coal_hit;
    logic                rec_last;
    logic [REC_W-1:0]    rec_in;
    logic [REC_W-1:0]    rec_out;
    logic                fifo_full;
    logic                fifo_empty;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REGS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign changed[gi] = enable && TRACK_MASK[gi] &&
                                 (io_value[gi*DATA_W +: DATA_W] != shadow_reg[gi]);
        end
    endgenerate

    assign pop         = out_ready && !fifo_empty;
    assign push_ok     = (|dirty_reg) && (!fifo_full || pop);
    assign push_idx    = lowest_set(dirty_reg);
    assign push_onehot = push_ok ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << push_idx) : '0;

    assign period_hit = (SNAP_PERIOD > 0) && enable && (period_cnt_reg == PERIOD_LAST);
    assign snap_trig  = snap_req || period_hit;

    // A re-change of the register being pushed this cycle is not a loss: the
    // record carries the old value and the bit is re-armed for the new one.
    assign coal_hit = |(changed & dirty_reg & ~push_onehot);

    always_comb begin
        dirty_next = (dirty_reg & ~push_onehot) | changed;
        if (snap_trig) begin
            dirty_next = dirty_next | TRACK_MASK;
        end
        dirty_next = dirty_next & TRACK_MASK;
        rec_last   = (dirty_next == '0);
        snap_next  = snap_trig || (snap_reg && (dirty_next != '0));
    end

    always_comb begin
        period_cnt_next = period_cnt_reg;
        if (enable && (SNAP_PERIOD > 0)) begin
            period_cnt_next = period_hit ? '0 : period_cnt_reg + 1'b1;
        end
        coalesce_next = coalesce_reg;
        if (coal_hit && (coalesce_reg != {COAL_W{1'b1}})) begin
            coalesce_next = coalesce_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_reg[i] <= '0;
            end
            dirty_reg      <= '0;
            snap_reg       <= 1'b0;
            period_cnt_reg <= '0;
            coreid_reg     <= '0;
            coalesce_reg   <= '0;
        end else begin
            if (enable) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    shadow_reg[i] <= io_value[i*DATA_W +: DATA_W];
                end
                coreid_reg <= io_coreid;
            end
            dirty_reg      <= dirty_next;
            snap_reg       <= snap_next;
            period_cnt_reg <= period_cnt_next;
            coalesce_reg   <= coalesce_next;
        end
    end

    assign rec_in = {push_idx, shadow_reg[push_idx], coreid_reg, snap_reg, rec_last};

    difftest_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_ok),
        .push_data (rec_in),
        .pop       (pop),
        .pop_data  (rec_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid    = !fifo_empty;
    assign out_last     = rec_out[REC_LAST_LSB];
    assign out_snap     = rec_out[REC_SNAP_LSB];
    assign out_coreid   = rec_out[REC_CORE_LSB +: COREID_W];
    assign out_data     = rec_out[REC_DATA_LSB +: DATA_W];
    assign out_idx      = rec_out[REC_DATA_LSB + DATA_W +: IDX_W];
    assign coalesce_cnt = coalesce_reg;
    assign busy         = (|dirty_reg) || !fifo_empty;

endmodule

// File: tb/tb_difftest_arch_reg_delta.sv
// Directed self-checking bench for difftest_arch_reg_delta (32 x 64-bit,
// 8-entry FIFO, snapshot every 4 enables, r0 skipped).
module tb_difftest_arch_reg_delta;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [2047:0] io_value;
    logic [7:0]    io_coreid;
    logic          snap_req;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    out_idx;
    logic [63:0]   out_data;
    logic [7:0]    out_coreid;
    logic          out_snap;
    logic          out_last;
    logic [15:0]   coalesce_cnt;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
        logic        snap;
        logic        last;
    } rec_t;
    rec_t recs[$];

    difftest_arch_reg_delta #(
        .NUM_REGS    (32),
        .DATA_W      (64),
        .FIFO_DEPTH  (8),
        .SNAP_PERIOD (4),
        .SKIP_R0     (1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .io_value     (io_value),
        .io_coreid    (io_coreid),
        .snap_req     (snap_req),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_data     (out_data),
        .out_coreid   (out_coreid),
        .out_snap     (out_snap),
        .out_last     (out_last),
        .coalesce_cnt (coalesce_cnt),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Capture every accepted record; handshake completes at the next rising edge
    always @(negedge clock) begin
        rec_t r;
        if (reset_n && out_valid && out_ready) begin
            r.idx  = out_idx;
            r.data = out_data;
            r.snap = out_snap;
            r.last = out_last;
            recs.push_back(r);
            $display("record idx=%0d data=0x%0h snap=%0b last=%0b", out_idx, out_data, out_snap, out_last);
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed still running, expected finished");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        snap_req = 1'b0;
        tick(2);
        reset_n = 1'b1;
        recs.delete();
        tick(1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        tick(1);
        check(tag, 64'(busy), 64'h0);
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic tally(output int n_snap, output int n_last, output int last_pos);
        n_snap   = 0;
        n_last   = 0;
        last_pos = -1;
        foreach (recs[i]) begin
            if (recs[i].snap) n_snap++;
            if (recs[i].last) begin
                n_last++;
                last_pos = i;
            end
        end
    endtask

    initial begin
        int ns, nl, lp;
        logic [4:0]  exp_idx [10];
        logic [63:0] exp_dat [10];

        reset_n   = 1'b0;
        enable    = 1'b0;
        io_value  = '0;
        io_coreid = 8'h00;
        snap_req  = 1'b0;
        out_ready = 1'b1;
        tick(2);

        // Reset state
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_idx", 64'(out_idx), 64'h0);
        check("rst_data", out_data, 64'h0);
        check("rst_last", 64'(out_last), 64'h0);
        check("rst_coal", 64'(coalesce_cnt), 64'h0);
        reset_n = 1'b1;
        tick(1);

        // Single change: x5 = 0x1234, 2-cycle latency
        io_value[5*64 +: 64] = 64'h1234;
        io_coreid = 8'h3C;
        pulse_enable();
        check("t1_valid_t1", 64'(out_valid), 64'h0);
        tick(1);
        check("t1_valid_t2", 64'(out_valid), 64'h1);
        check("t1_idx", 64'(out_idx), 64'h5);
        check("t1_data", out_data, 64'h1234);
        check("t1_coreid", 64'(out_coreid), 64'h3C);
        check("t1_snap", 64'(out_snap), 64'h0);
        check("t1_last", 64'(out_last), 64'h1);
        tick(1);
        check("t1_valid_after", 64'(out_valid), 64'h0);
        check("t1_busy_after", 64'(busy), 64'h0);
        check("t1_count", 64'(recs.size()), 64'h1);

        // Three changes under backpressure
        do_reset();
        out_ready = 1'b0;
        io_value = '0;
        io_value[1*64 +: 64]  = 64'h11;
        io_value[3*64 +: 64]  = 64'h33;
        io_value[31*64 +: 64] = 64'h3131;
        pulse_enable();
        tick(10);
        check("t2_stall_valid", 64'(out_valid), 64'h1);
        check("t2_stall_idx", 64'(out_idx), 64'h1);
        check("t2_stall_data", out_data, 64'h11);
        check("t2_stall_none", 64'(recs.size()), 64'h0);
        out_ready = 1'b1;
        wait_idle("t2_idle", 20);
        check("t2_count", 64'(recs.size()), 64'h3);
        if (recs.size() == 3) begin
            check("t2_idx0", 64'(recs[0].idx), 64'h1);
            check("t2_idx1", 64'(recs[1].idx), 64'h3);
            check("t2_idx2", 64'(recs[2].idx), 64'h1F);
            check("t2_data2", recs[2].data, 64'h3131);
            check("t2_last0", 64'(recs[0].last), 64'h0);
            check("t2_last1", 64'(recs[1].last), 64'h0);
            check("t2_last2", 64'(recs[2].last), 64'h1);
        end

        // Coalescing while the FIFO is full
        do_reset();
        check("t3_coal_rst", 64'(coalesce_cnt), 64'h0);
        out_ready = 1'b0;
        io_value = '0;
        for (int i = 1; i <= 9; i++) io_value[i*64 +: 64] = 64'(i * 256);
        pulse_enable();
        tick(12);
        check("t3_full_busy", 64'(busy), 64'h1);
        io_value[7*64 +: 64] = 64'hA;
        enable = 1'b1;
        tick(1);
        io_value[7*64 +: 64] = 64'hB;
        tick(1);
        enable = 1'b0;
        check("t3_coal", 64'(coalesce_cnt), 64'h1);
        out_ready = 1'b1;
        wait_idle("t3_idle", 40);
        check("t3_count", 64'(recs.size()), 64'hA);
        for (int i = 0; i < 8; i++) begin
            exp_idx[i] = 5'(i + 1);
            exp_dat[i] = 64'((i + 1) * 256);
        end
        exp_idx[8] = 5'd7; exp_dat[8] = 64'hB;
        exp_idx[9] = 5'd9; exp_dat[9] = 64'h900;
        if (recs.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                check($sformatf("t3_idx%0d", i), 64'(recs[i].idx), 64'(exp_idx[i]));
                check($sformatf("t3_data%0d", i), recs[i].data, exp_dat[i]);
            end
            tally(ns, nl, lp);
            check("t3_last_pos", 64'(lp), 64'h9);
            check("t3_last_cnt", 64'(nl), 64'h1);
        end

        // snap_req full snapshot
        do_reset();
        io_value = '0;
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        check("t4_valid_t1", 64'(out_valid), 64'h0);
        tick(1);
        check("t4_valid_t2", 64'(out_valid), 64'h1);
        check("t4_snap_t2", 64'(out_snap), 64'h1);
        check("t4_idx_t2", 64'(out_idx), 64'h1);
        wait_idle("t4_idle", 60);
        check("t4_count", 64'(recs.size()), 64'd31);
        if (recs.size() == 31) begin
            for (int i = 0; i < 31; i++) begin
                check($sformatf("t4_idx%0d", i), 64'(recs[i].idx), 64'(i + 1));
                check($sformatf("t4_snap%0d", i), 64'(recs[i].snap), 64'h1);
                check($sformatf("t4_last%0d", i), 64'(recs[i].last), 64'(i == 30));
            end
        end

        // Periodic snapshot every 4th enable
        do_reset();
        io_value = '0;
        io_value[0 +: 64] = 64'hFFFF;
        for (int i = 1; i < 32; i++) io_value[i*64 +: 64] = 64'(i * 16 + 5);
        pulse_enable();
        wait_idle("t5_idle1", 60);
        tally(ns, nl, lp);
        check("t5_delta_count", 64'(recs.size()), 64'd31);
        check("t5_delta_snaps", 64'(ns), 64'h0);
        pulse_enable();
        tick(3);
        pulse_enable();
        tick(3);
        check("t5_quiet", 64'(recs.size()), 64'd31);
        recs.delete();
        pulse_enable();
        wait_idle("t5_idle4", 60);
        tally(ns, nl, lp);
        check("t5_snap4_count", 64'(recs.size()), 64'd31);
        check("t5_snap4_snaps", 64'(ns), 64'd31);
        check("t5_snap4_lastpos", 64'(lp), 64'd30);
        if (recs.size() == 31) begin
            check("t5_snap4_first_idx", 64'(recs[0].idx), 64'h1);
            check("t5_snap4_first_data", recs[0].data, 64'h15);
            check("t5_snap4_end_data", recs[30].data, 64'h1F5);
        end
        recs.delete();
        for (int k = 0; k < 3; k++) begin
            pulse_enable();
            tick(3);
        end
        check("t5_quiet2", 64'(recs.size()), 64'h0);
        pulse_enable();
        wait_idle("t5_idle8", 60);
        tally(ns, nl, lp);
        check("t5_snap8_count", 64'(recs.size()), 64'd31);
        check("t5_snap8_snaps", 64'(ns), 64'd31);

        // Reset with records pending
        do_reset();
        out_ready = 1'b0;
        io_value = '0;
        for (int i = 1; i <= 5; i++) io_value[i*64 +: 64] = 64'(i * 170);
        pulse_enable();
        tick(8);
        check("t6_pend_valid", 64'(out_valid), 64'h1);
        check("t6_pend_busy", 64'(busy), 64'h1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'h0);
        check("t6_rst_busy", 64'(busy), 64'h0);
        check("t6_rst_data", out_data, 64'h0);
        check("t6_rst_idx", 64'(out_idx), 64'h0);
        tick(1);
        reset_n = 1'b1;
        recs.delete();
        tick(1);
        io_value = '0;
        out_ready = 1'b1;
        pulse_enable();
        tick(5);
        check("t6_post_valid", 64'(out_valid), 64'h0);
        check("t6_post_busy", 64'(busy), 64'h0);
        check("t6_post_count", 64'(recs.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
